pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised, elastic pipeline register for the RISC-V core. Replaces the fixed-field, free-running inter-stage registers (E→M and others).
- Carries an opaque data bundle and a control bundle through DEPTH register stages.
- Per-stage valid bits, valid/ready backpressure (stall), bubble collapse, and flush that squashes control bits so killed instructions cannot write registers or memory.

Parameters:
- DATA_WIDTH, 32: width of the datapath bundle (e.g. ALU result, write data, PC target, PC+4, rd, concatenated). Never cleared except on reset.
- CTRL_WIDTH, 8: width of the control bundle (e.g. RegWrite, MemWrite, ResultSrc, jump selects). Forced to 0 in any invalid stage.
- DEPTH, 1: number of register stages, legal range 1..8.

Ports:
- clk, input, 1: rising-edge clock.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: upstream presents a beat.
- in_ready, output, 1: stage 0 can load this cycle.
- in_data, input, DATA_WIDTH: upstream datapath bundle.
- in_ctrl, input, CTRL_WIDTH: upstream control bundle.
- flush, input, 1: squash all in-flight beats and the incoming beat.
- out_valid, output, 1: last stage holds a valid beat.
- out_ready, input, 1: downstream accepts; 0 = stall.
- out_data, output, DATA_WIDTH: last stage datapath bundle.
- out_ctrl, output, CTRL_WIDTH: last stage control bundle; 0 whenever out_valid=0.
- occupancy, output, $clog2(DEPTH+1): count of valid stages.

Behaviour:
- State per stage k (0 = input side, DEPTH-1 = output side): v[k], d[k], c[k].

Reset:
- On the rst edge: all v=0, d=0, c=0.
- Therefore out_valid=0, out_data=0, out_ctrl=0, occupancy=0, and in_ready=1 on the first cycle after reset.
- rst overrides flush and all handshakes. Reset mid-stream discards every in-flight beat.

Advance logic (combinational):
- adv[DEPTH-1] = out_ready | ~v[DEPTH-1].
- adv[k] = adv[k+1] | ~v[k] for k < DEPTH-1. An empty stage always loads; this is bubble collapse.
- in_ready = adv[0].
- The ready path is purely combinational, with depth DEPTH. No registered-ready/skid mode in this block.

Load rule on clk edge, when adv[k]=1:
- Source is stage k-1, or the input port for k=0. The source valid for stage 0 is in_valid.
- v[k] <= source valid.
- d[k] <= source data. It loads even when invalid; the value is don't-care but deterministic.
- c[k] <= source valid ? source ctrl : 0.

Hold rule:
- When adv[k]=0, stage k holds all its fields.

Transfers:
- Output transfer occurs when out_valid & out_ready.
- Input transfer occurs when in_valid & in_ready.

Flush:
- Flush has priority over load and hold. On the flush edge: all v <= 0 and all c <= 0; d is held.
- An input beat presented in the flush cycle is consumed and dropped (in_ready still follows adv[0]).
- Flush together with out_ready=1: the output beat in that cycle counts as delivered to downstream. Flush only affects register state at the edge.

Throughput and latency:
- With out_ready held at 1: one beat per cycle; input-to-output latency is exactly DEPTH cycles.
- DEPTH=1, out_ready=1, v=1: simultaneous input and output transfer in the same cycle is legal and required.

Stall:
- out_ready=0 with a full pipe: every stage holds, in_ready=0, and occupancy=DEPTH. in_data is ignored.
- out_ready=0 with a partially full pipe: beats advance into empty stages until the pipe is full. in_ready drops only when every stage is valid.

Occupancy:
- Registered state count, equal to the popcount of v. Updates one cycle after the transfers that change it.

Test Plan:
- DEPTH=3, reset, then in_valid=1 streaming d=0x10,0x11,0x12,0x13 with c=0xA5, out_ready=1 → out_valid rises on cycle 3 with out_data=0x10; one beat per cycle after that, out_ctrl=0xA5; occupancy steady at 3.
- DEPTH=3, pipe full, out_ready=0 for 4 cycles → in_ready=0, out_data holds 0x10, occupancy=3; on release, 0x11 follows 0x10 in consecutive cycles, with no loss or duplication.
- DEPTH=3, single beat d=0x55 then in_valid=0, out_ready=0 → beat collapses to the output by cycle 3; occupancy=1; in_ready stays 1 throughout.
- DEPTH=3, full pipe with c=0xFF, flush=1 for one cycle while in_valid=1 → next cycle out_valid=0, out_ctrl=0x00, occupancy=0; the flushed-cycle input never appears at the output.
- DEPTH=1, alternating out_ready 1/0, in_valid=1 continuously → each beat delivered exactly once and in order; in_ready equals out_ready whenever v=1.
- rst asserted mid-stream with occupancy=2 → next cycle all outputs are 0 and in_ready=1; beats injected afterwards emerge after exactly DEPTH cycles.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic multi-stage pipeline register with valid/ready and flush
//
// Purpose:
//   Carries an opaque datapath bundle and a control bundle through DEPTH
//   register stages. Each stage has its own valid bit. Empty stages always
//   load, so bubbles collapse toward the output. A flush squashes every valid
//   bit and every control bundle, so a killed instruction cannot cause a
//   register or memory write downstream. The datapath bundle is only cleared
//   by reset.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (overrides flush and handshakes)
//   in_valid   upstream presents a beat
//   in_ready   stage 0 can load this cycle
//   in_data    upstream datapath bundle
//   in_ctrl    upstream control bundle
//   flush      squash all in-flight beats and the incoming beat
//   out_valid  last stage holds a valid beat
//   out_ready  downstream accepts (0 = stall)
//   out_data   last stage datapath bundle
//   out_ctrl   last stage control bundle, 0 whenever out_valid is 0
//   occupancy  number of valid stages (registered)

module pipe_stage_reg #(
   parameter int  DATA_WIDTH = 32,
   parameter int  CTRL_WIDTH = 8,
   parameter int  DEPTH      = 1,
   localparam int OCC_W      = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic [CTRL_WIDTH-1:0] in_ctrl,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CTRL_WIDTH-1:0] out_ctrl,
   output logic [OCC_W-1:0]      occupancy
);

   // Stage 0 is the input side, stage DEPTH-1 drives the outputs.
   logic [DEPTH-1:0]      v;
   logic [DATA_WIDTH-1:0] d [DEPTH];
   logic [CTRL_WIDTH-1:0] c [DEPTH];

   logic [DEPTH-1:0]      adv;
   logic [DEPTH-1:0]      v_next;
   logic [CTRL_WIDTH-1:0] c_next [DEPTH];

   logic [DEPTH-1:0]      src_v;
   logic [DATA_WIDTH-1:0] src_d [DEPTH];
   logic [CTRL_WIDTH-1:0] src_c [DEPTH];

   logic                  tail_full;

   // A stage may advance unless it and every stage after it are valid while
   // the output is stalled. This is the adv[k] = adv[k+1] | ~v[k] chain
   // unrolled from the output side, so no signal depends on itself.
   always_comb begin
      adv       = '0;
      tail_full = 1'b1;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         tail_full = tail_full & v[k];
         adv[k]    = out_ready | ~tail_full;
      end
   end

   // Load source for each stage: the input port for stage 0, the previous
   // stage otherwise.
   always_comb begin
      src_v    = '0;
      src_v[0] = in_valid;
      src_d[0] = in_data;
      src_c[0] = in_ctrl;
      for (int k = 1; k < DEPTH; k++) begin
         src_v[k] = v[k-1];
         src_d[k] = d[k-1];
         src_c[k] = c[k-1];
      end
   end

   // Valid and control next state. Flush wins over load and hold; an invalid
   // beat always carries a zero control bundle.
   always_comb begin
      v_next = v;
      for (int k = 0; k < DEPTH; k++) begin
         c_next[k] = c[k];
         if (flush) begin
            v_next[k] = 1'b0;
            c_next[k] = '0;
         end else if (adv[k]) begin
            v_next[k] = src_v[k];
            c_next[k] = src_v[k] ? src_c[k] : '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v         <= '0;
         occupancy <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d[k] <= '0;
            c[k] <= '0;
         end
      end else begin
         v         <= v_next;
         occupancy <= OCC_W'($countones(v_next));
         for (int k = 0; k < DEPTH; k++) begin
            c[k] <= c_next[k];
            // Data loads even for invalid beats; flush leaves it untouched.
            if (adv[k] && !flush) begin
               d[k] <= src_d[k];
            end
         end
      end
   end

   assign in_ready  = adv[0];
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];
   assign out_ctrl  = c[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - scoreboard bench for pipe_stage_reg at DEPTH 3 and DEPTH 1
module tb_pipe_stage_reg;

   localparam int DW = 32;
   localparam int CW = 8;

   typedef struct {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      int            pos;
   } beat_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic          iv   [2];
   logic          ir   [2];
   logic [DW-1:0] idata[2];
   logic [CW-1:0] ictrl[2];
   logic          fl   [2];
   logic          ov   [2];
   logic          ordy [2];
   logic [DW-1:0] od   [2];
   logic [CW-1:0] oc   [2];
   logic [1:0]    occ0;
   logic [0:0]    occ1;

   // Scoreboard per instance: accepted beats oldest first, each with the
   // stage it should currently occupy.
   beat_t         sb [2][$];
   logic          acc     [2];
   logic          just_rst[2];
   logic [DW-1:0] nd      [2];
   logic          checking = 1'b0;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(3)) u_d3 (
      .clk(clk), .rst(rst),
      .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata[0]), .in_ctrl(ictrl[0]),
      .flush(fl[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .out_ctrl(oc[0]),
      .occupancy(occ0)
   );

   pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .DEPTH(1)) u_d1 (
      .clk(clk), .rst(rst),
      .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata[1]), .in_ctrl(ictrl[1]),
      .flush(fl[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .out_ctrl(oc[1]),
      .occupancy(occ1)
   );

   function automatic int dep(input int i);
      return (i == 0) ? 3 : 1;
   endfunction

   task automatic chk(input string nm, input int i, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL u%0d %s got %h want %h at %0t", i, nm, act, exp, $time);
   endtask

   // Monitor: every output transfer pops the oldest expected beat.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (checking && !rst && ov[i] === 1'b1 && ordy[i]) begin
            if (sb[i].size() == 0) begin
               n_total++;
               $display("FAIL u%0d sb_extra got beat %h want none at %0t", i, od[i], $time);
            end else begin
               beat_t b;
               b = sb[i].pop_front();
               chk("sb_data", i, od[i], b.d);
               chk("sb_ctrl", i, DW'(oc[i]), DW'(b.c));
            end
         end
      end
   end

   task automatic check_outputs(input int i);
      int   cnt;
      int   occv;
      logic eov;
      logic eir;
      cnt  = sb[i].size();
      occv = (i == 0) ? int'(occ0) : int'(occ1);
      eov  = (cnt > 0) && (sb[i][0].pos == dep(i) - 1);
      // Stage 0 can load unless every stage is full and the output stalls.
      eir  = ordy[i] | (cnt < dep(i));
      chk("out_valid", i, DW'(ov[i]), DW'(eov));
      chk("in_ready",  i, DW'(ir[i]), DW'(eir));
      chk("occupancy", i, DW'(occv),  DW'(cnt));
      if (eov) begin
         chk("out_data", i, od[i], sb[i][0].d);
         chk("out_ctrl", i, DW'(oc[i]), DW'(sb[i][0].c));
      end else begin
         chk("ctrl_zero", i, DW'(oc[i]), '0);
         if (just_rst[i]) chk("rst_data", i, od[i], '0);
      end
      acc[i] = iv[i] & eir;
   endtask

   // Each beat moves one stage per cycle but never into or past the stage
   // its predecessor ends up in; the oldest beat stops at the last stage.
   task automatic update_model(input int i);
      int lim;
      int np;
      if (rst) begin
         sb[i].delete();
         just_rst[i] = 1'b1;
         return;
      end
      just_rst[i] = 1'b0;
      if (fl[i]) begin
         sb[i].delete();
         return;
      end
      lim = dep(i);
      for (int j = 0; j < sb[i].size(); j++) begin
         np = sb[i][j].pos + 1;
         if (np > lim - 1) np = lim - 1;
         sb[i][j].pos = np;
         lim = np;
      end
      if (acc[i]) begin
         beat_t b;
         b.d = idata[i];
         b.c = ictrl[i];
         b.pos = 0;
         sb[i].push_back(b);
         nd[i] = nd[i] + 1;
      end
   endtask

   // Called at posedge+1 with inputs already driven; returns at the next
   // posedge+1.
   task automatic step();
      #2;
      if (checking) begin
         check_outputs(0);
         check_outputs(1);
      end
      @(negedge clk);
      #1;
      update_model(0);
      update_model(1);
      if (rst) checking = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Directed cycle for the DEPTH-3 unit; the DEPTH-1 unit streams
   // continuously with out_ready alternating every cycle.
   task automatic run(input logic v, input logic r, input logic f,
                      input logic [CW-1:0] c, input int n);
      for (int t = 0; t < n; t++) begin
         iv[0] = v;  ordy[0] = r;  fl[0] = f;  ictrl[0] = c;  idata[0] = nd[0];
         iv[1] = 1'b1;  fl[1] = 1'b0;  ictrl[1] = 8'h3C;  idata[1] = nd[1];
         ordy[1] = ~ordy[1];
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0;  ordy[i] = 1'b0;  fl[i] = 1'b0;
         idata[i] = '0; ictrl[i] = '0;  acc[i] = 1'b0;  just_rst[i] = 1'b0;
      end
      nd[0] = 32'h10;
      nd[1] = 32'h100;
      @(posedge clk);
      #1;
      rst = 1'b1;
      run(1'b0, 1'b0, 1'b0, 8'h00, 2);
      rst = 1'b0;

      // Stream with a 4-cycle stall once the pipe is full, then drain.
      nd[0] = 32'h10;
      run(1'b1, 1'b1, 1'b0, 8'hA5, 3);
      run(1'b1, 1'b0, 1'b0, 8'hA5, 4);
      run(1'b1, 1'b1, 1'b0, 8'hA5, 6);
      run(1'b0, 1'b1, 1'b0, 8'hA5, 4);

      // Single beat collapses to the output while stalled.
      nd[0] = 32'h55;
      run(1'b1, 1'b0, 1'b0, 8'h5A, 1);
      run(1'b0, 1'b0, 1'b0, 8'h5A, 5);
      run(1'b0, 1'b1, 1'b0, 8'h5A, 2);

      // Fill with all-ones control, then flush while a beat is offered.
      nd[0] = 32'h200;
      run(1'b1, 1'b0, 1'b0, 8'hFF, 4);
      run(1'b1, 1'b0, 1'b1, 8'hFF, 1);
      run(1'b0, 1'b1, 1'b0, 8'hFF, 4);

      // Reset with two beats in flight, then stream again.
      nd[0] = 32'h300;
      run(1'b1, 1'b0, 1'b0, 8'h77, 2);
      rst = 1'b1;
      run(1'b1, 1'b1, 1'b0, 8'h77, 1);
      rst = 1'b0;
      run(1'b1, 1'b1, 1'b0, 8'h66, 6);
      run(1'b0, 1'b1, 1'b0, 8'h66, 4);

      // Randomised traffic on both units.
      for (int t = 0; t < 600; t++) begin
         for (int i = 0; i < 2; i++) begin
            iv[i]    = ($urandom_range(0, 3) != 0);
            ordy[i]  = ($urandom_range(0, 3) != 0);
            fl[i]    = ($urandom_range(0, 29) == 0);
            idata[i] = $urandom;
            ictrl[i] = CW'($urandom);
         end
         rst = ($urandom_range(0, 149) == 0);
         step();
      end
      rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         iv[i] = 1'b0;  ordy[i] = 1'b1;  fl[i] = 1'b0;
      end
      for (int t = 0; t < 5; t++) step();
      for (int i = 0; i < 2; i++) begin
         n_total++;
         if (sb[i].size() == 0) n_pass++;
         else $display("FAIL u%0d drain got %0d beats left want 0", i, sb[i].size());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
